// File: rtl/fetch_unit_rv32i_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Canonical NOP (addi x0, x0, 0) for downstream bubble insertion.
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    // REQ: request driven, WAIT: accepted and awaiting response,
    // HOLD: instruction presented to decode, DROP: squash next response.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_rv32i_if.sv
// Instruction-memory bus: valid/ready request channel plus valid-only response.
interface fetch_unit_rv32i_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    // Fetch unit side.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Instruction memory side.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/fetch_unit_rv32i.sv
// RV32I fetch front end: owns the PC, keeps one request outstanding to
// instruction memory, and presents each returned word to decode.
module fetch_unit_rv32i
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,

    fetch_unit_rv32i_if.master  imem,

    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [XLEN-1:0]     inst_data,
    output logic [XLEN-1:0]     inst_pc,
    output logic [XLEN-1:0]     inst_pc_plus4,
    output logic                misalign_err
);

    fetch_state_e    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;

    // Wraps naturally at 2^32.
    assign pc_plus4        = pc + 32'd4;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

    // Request side depends only on registered state; rst masks it during reset.
    assign imem.imem_req_valid = (state == REQ) && !rst;
    assign imem.imem_req_addr  = pc;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

    // Fetch FSM, PC and the registered decode-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= REQ;
            pc            <= RESET_PC;
            inst_valid    <= 1'b0;
            inst_data     <= '0;
            inst_pc       <= RESET_PC;
            inst_pc_plus4 <= RESET_PC + 32'd4;
            misalign_err  <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);

            if (redirect_valid) begin
                pc <= redirect_target;
                unique case (state)
                    // An accepted request must have its response squashed.
                    REQ:  state <= req_fire ? DROP : REQ;
                    // A response in the same cycle is the one being squashed.
                    WAIT: state <= imem.imem_rsp_valid ? REQ : DROP;
                    HOLD: begin
                        inst_valid <= 1'b0;
                        state      <= REQ;
                    end
                    // If the squashed response lands now, there is nothing left
                    // to drop; waiting longer would stall forever.
                    DROP: state <= imem.imem_rsp_valid ? REQ : DROP;
                    default: state <= REQ;
                endcase
            end else begin
                unique case (state)
                    REQ: begin
                        if (req_fire) begin
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (imem.imem_rsp_valid) begin
                            inst_data     <= imem.imem_rsp_data;
                            inst_pc       <= pc;
                            inst_pc_plus4 <= pc_plus4;
                            inst_valid    <= 1'b1;
                            state         <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (inst_ready) begin
                            pc         <= pc_plus4;
                            inst_valid <= 1'b0;
                            state      <= REQ;
                        end
                    end
                    DROP: begin
                        if (imem.imem_rsp_valid) begin
                            state <= REQ;
                        end
                    end
                    default: state <= REQ;
                endcase
            end
        end
    end

endmodule
